regfile_wb_demux: RTL and testbench

- 32x32-bit MIPS register file for the single-cycle core.
- Takes the single write-back data bus and fans it out through a 5-to-32 one-hot write decoder (1-to-32 demux) to the addressed register; feeds two combinational read ports.
- The rs/rt values from the read ports drive the ALU operand selection stage.
- Register $0 is hardwired to zero.

---
 rtl/regfile_wb_demux.sv | 120 ++++++++++++
 tb/tb_regfile_wb_demux.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_demux.sv
// -----------------------------------------------------------------------------
// regfile_wb_demux
//   32x32-bit MIPS register file for the single-cycle core. The single
//   write-back bus is steered into the addressed register through a 5-to-32
//   one-hot write decoder. Two combinational read ports feed the ALU operand
//   selection stage. Register $0 is hardwired to zero.
//
// Parameters
//   DATA_W   : register / data bus width
//   ADDR_W   : register address width, depth = 2**ADDR_W
//   ZERO_REG : index of the hardwired-zero register
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (clears registers, wr_onehot)
//   reg_write in   write enable (RegWrite)
//   wr_addr   in   destination register
//   wr_data   in   write-back data
//   rd_addr1  in   read port 1 address (rs)
//   rd_addr2  in   read port 2 address (rt)
//   rd_data1  out  read port 1 data, combinational
//   rd_data2  out  read port 2 data, combinational
//   wr_onehot out  registered one-hot of the last committed write (debug/trace)
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a read whose address matches an active
//   write (other than the zero register) returns wr_data in the same cycle.
//   Undefined (default): reads always return stored contents.
// -----------------------------------------------------------------------------
module regfile_wb_demux #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_write,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic [(2**ADDR_W)-1:0] wr_onehot
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  dec;

  // One-hot write decoder; the zero register never gets a strobe.
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely
    // combinational; any path leaving dec unassigned would infer a latch.
    dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = reg_write && (wr_addr == ADDR_W'(i));
    end
    dec[ZERO_REG] = 1'b0;
  end

  // Register array. Every entry is cleared by reset because the architectural
  // state must be zero after reset and reads must show 0 while in reset.
  // NOTE: resetting a memory forces it into flops rather than an SRAM macro;
  // that is intended here, a 32-entry register file is flop-based anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values;
        // blocking here would create order-dependent simulation behaviour.
        if (dec[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Trace register: records which register (if any) was written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_onehot <= '0;
    end else begin
      wr_onehot <= dec;
    end
  end

  // Read ports. The zero register is forced to 0 regardless of storage.
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    // Write-through forwarding; the zero register is excluded below because
    // dec never strobes it and the explicit zero check wins.
    if (reg_write && (wr_addr == rd_addr1) && (wr_addr != ZERO_ADDR)) begin
      rd_data1 = wr_data;
    end
    if (reg_write && (wr_addr == rd_addr2) && (wr_addr != ZERO_ADDR)) begin
      rd_data2 = wr_data;
    end
    if (rd_addr1 == ZERO_ADDR) begin
      rd_data1 = '0;
    end
    if (rd_addr2 == ZERO_ADDR) begin
      rd_data2 = '0;
    end
  end
`else
  always_comb begin
    rd_data1 = (rd_addr1 == ZERO_ADDR) ? '0 : regs[rd_addr1];
    rd_data2 = (rd_addr2 == ZERO_ADDR) ? '0 : regs[rd_addr2];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_demux.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_demux
//   Directed, table-driven bench for regfile_wb_demux plus hand-written
//   sequences for reset, read-during-write and a full write/read sweep.
// -----------------------------------------------------------------------------
module tb_regfile_wb_demux;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [31:0] wr_onehot;

  int checks = 0;
  int errors = 0;

  regfile_wb_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_write (reg_write),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .wr_onehot (wr_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_onehot;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, sample 1 ns after the
  // rising edge.
  task automatic cycle(input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic [4:0] ra1,
                       input logic [4:0] ra2);
    @(negedge clk);
    reg_write = we;
    wr_addr   = waddr;
    wr_data   = wdata;
    rd_addr1  = ra1;
    rd_addr2  = ra2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_val;

    // Post-edge expectations: reads reflect the write just committed.
    vecs[0] = '{1'b1, 5'd8,  32'h12345678, 5'd8,  5'd0,
                32'h12345678, 32'h00000000, 32'h00000100};
    vecs[1] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd8,
                32'hCAFEF00D, 32'h12345678, 32'h80000000};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd31,
                32'h00000000, 32'hCAFEF00D, 32'h00000000};
    vecs[3] = '{1'b0, 5'd9,  32'hAAAA5555, 5'd9,  5'd9,
                32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 5'd8,  32'h0F0F0F0F, 5'd8,  5'd31,
                32'h0F0F0F0F, 32'hCAFEF00D, 32'h00000100};

    rst_n     = 1'b0;
    reg_write = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr1  = 5'd5;
    rd_addr2  = 5'd31;

    // Reset state.
    #2;
    check("reset_rd1", rd_data1, 32'h0);
    check("reset_rd2", rd_data2, 32'h0);
    check("reset_onehot", wr_onehot, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].raddr1, vecs[i].raddr2);
      check($sformatf("vec%0d_rd1", i), rd_data1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_rd2", i), rd_data2, vecs[i].exp_rd2);
      check($sformatf("vec%0d_onehot", i), wr_onehot, vecs[i].exp_onehot);
    end

    // Idle cycle clears the trace register.
    cycle(1'b0, 5'd8, 32'h0, 5'd8, 5'd8);
    check("idle_onehot", wr_onehot, 32'h0);

    // Read-during-write to the same address from both ports.
    cycle(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3);
    check("rdw_setup", rd_data1, 32'h11111111);
    @(negedge clk);
    reg_write = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 32'h22222222;
    rd_addr1  = 5'd3;
    rd_addr2  = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_val = 32'h22222222;
`else
    exp_val = 32'h11111111;
`endif
    check("rdw_pre_rd1", rd_data1, exp_val);
    check("rdw_pre_rd2", rd_data2, exp_val);
    @(posedge clk);
    #1;
    check("rdw_post_rd1", rd_data1, 32'h22222222);
    check("rdw_post_rd2", rd_data2, 32'h22222222);
    check("rdw_onehot", wr_onehot, 32'h00000008);

    // Write to $0 while reading $0 on both ports: never forwarded.
    @(negedge clk);
    reg_write = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'h5A5A5A5A;
    rd_addr1  = 5'd0;
    rd_addr2  = 5'd0;
    #1;
    check("zero_pre_rd1", rd_data1, 32'h0);
    @(posedge clk);
    #1;
    check("zero_post_rd2", rd_data2, 32'h0);

    // Exhaustive sweep: r1..r31 <= i * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      cycle(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      check($sformatf("sweep_onehot%0d", i), wr_onehot, 32'h1 << i);
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_r%0d", i), rd_data1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_r%0d", 31 - i), rd_data2,
            32'(31 - i) * 32'h01010101);
    end

    // Asynchronous reset mid-cycle after loading r5.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    check("pre_reset_r5", rd_data1, 32'hDEADBEEF);
    @(negedge clk);
    reg_write = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_rd1", rd_data1, 32'h0);
    check("async_reset_onehot", wr_onehot, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted during a write cycle: reset wins.
    cycle(1'b1, 5'd5, 32'h01234567, 5'd5, 5'd6);
    check("reload_r5", rd_data1, 32'h01234567);
    @(negedge clk);
    reg_write = 1'b1;
    wr_addr   = 5'd5;
    wr_data   = 32'h76543210;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("reset_wins_r5", rd_data1, 32'h0);
    check("reset_wins_onehot", wr_onehot, 32'h0);
    @(negedge clk);
    reg_write = 1'b0;
    rst_n     = 1'b1;
    // First edge after release resumes normal writes.
    cycle(1'b1, 5'd6, 32'h600DF00D, 5'd6, 5'd5);
    check("post_reset_r6", rd_data1, 32'h600DF00D);
    check("post_reset_r5", rd_data2, 32'h0);
    check("post_reset_onehot", wr_onehot, 32'h00000040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
